// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - control sequencer for a shift-and-add multiplier datapath
// Turns one start press into a load cycle, WORD_LENGTH iterate cycles and a one-cycle done pulse.
module mult_sequencer #(
  parameter int WORD_LENGTH       = 16,
  parameter int NBITS_FOR_COUNTER = $clog2(WORD_LENGTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         multiplier_lsb,
  output logic                         load,
  output logic                         shift_en,
  output logic                         add_en,
  output logic                         busy,
  output logic                         done,
  output logic [NBITS_FOR_COUNTER-1:0] iteration
);

  typedef enum logic [2:0] {
    WAIT_RELEASE = 3'd0,
    IDLE         = 3'd1,
    LOAD         = 3'd2,
    ITERATE      = 3'd3,
    DONE         = 3'd4
  } state_t;

  localparam logic [NBITS_FOR_COUNTER-1:0] LAST_ITER = NBITS_FOR_COUNTER'(WORD_LENGTH - 1);

  state_t                         state_q, state_d;
  logic [NBITS_FOR_COUNTER-1:0]   counter_q, counter_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WAIT_RELEASE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // The counter only holds a nonzero value while iterating, so it restarts at 0 after any abort.
  always_comb begin
    state_d   = state_q;
    counter_d = '0;
    load      = 1'b0;
    shift_en  = 1'b0;
    add_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    iteration = '0;
    case (state_q)
      WAIT_RELEASE: begin
        if (!start) state_d = IDLE;
      end
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        busy    = 1'b1;
        state_d = ITERATE;
      end
      ITERATE: begin
        shift_en  = 1'b1;
        busy      = 1'b1;
        add_en    = multiplier_lsb;
        iteration = counter_q;
        if (counter_q == LAST_ITER) state_d = DONE;
        else                        counter_d = counter_q + 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        // A start still held here must be released before the next operation.
        state_d = start ? WAIT_RELEASE : IDLE;
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - scoreboard bench for mult_sequencer with a behavioural datapath
module tb_mult_sequencer;

  localparam int WL = 16;
  localparam int NB = $clog2(WL + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          multiplier_lsb;
  logic          load, shift_en, add_en, busy, done;
  logic [NB-1:0] iteration;

  mult_sequencer #(.WORD_LENGTH(WL)) dut (
    .clk(clk), .reset(reset), .start(start), .multiplier_lsb(multiplier_lsb),
    .load(load), .shift_en(shift_en), .add_en(add_en), .busy(busy),
    .done(done), .iteration(iteration)
  );

  always #5 clk = ~clk;

  // Datapath driven by the sequencer outputs.
  logic [15:0] op_a = 16'h0, op_b = 16'h0;
  logic        lsb_force = 1'b0;
  logic [31:0] mcand = '0, prod = '0;
  logic [15:0] mplier = '0;

  assign multiplier_lsb = mplier[0] | lsb_force;

  always @(posedge clk) begin
    if (load) begin
      mcand  <= {16'h0, op_a};
      mplier <= op_b;
      prod   <= '0;
    end else if (shift_en) begin
      if (add_en) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Reference model: an operation is a timeline phase 0 (load), 1..WL (iterate), WL+1 (done).
  int          phase = -1;
  bit          armed = 1'b0;
  logic [15:0] mb = '0;
  logic [31:0] mprod = '0;

  logic [9:0]  exp_q[$];
  logic [31:0] prod_q[$];

  int checks = 0;
  int errors = 0;

  task automatic model_step();
    logic sh;
    logic [NB-1:0] it;
    if (!reset) begin
      phase = -1;
      armed = 1'b0;
    end else if (phase >= 0) begin
      if (phase == WL + 1) begin
        phase = -1;
        armed = !start;
      end else begin
        phase++;
      end
    end else if (armed) begin
      if (start) begin
        phase = 0;
        mb    = lsb_force ? 16'hFFFF : op_b;
        mprod = 32'(op_a) * 32'(mb);
      end
    end else if (!start) begin
      armed = 1'b1;
    end
    if (phase == WL + 1) prod_q.push_back(mprod);
    sh = (phase >= 1) && (phase <= WL);
    it = sh ? NB'(phase - 1) : '0;
    exp_q.push_back({phase == 0, sh, sh && mb[sh ? phase - 1 : 0],
                     (phase >= 0) && (phase <= WL), phase == WL + 1, it});
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #2;
      if (phase < 0 && !lsb_force) begin
        op_a = 16'($urandom);
        op_b = 16'($urandom);
      end
    end
  endtask

  task automatic press(input logic [15:0] a, input logic [15:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: compares every cycle's outputs and the product whenever done is presented.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [9:0] act;
    logic [31:0] ep;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {load, shift_en, add_en, busy, done, iteration};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs t=%0t {load,shift,add,busy,done,iter} actual=%b required=%b", $time, act, e);
      end
      if (done === 1'b1) begin
        checks++;
        if (prod_q.size() == 0) begin
          errors++;
          $display("FAIL product t=%0t unexpected done, product=%h", $time, prod);
        end else begin
          ep = prod_q.pop_front();
          if (prod !== ep) begin
            errors++;
            $display("FAIL product t=%0t actual=%h required=%h", $time, prod, ep);
          end
        end
      end
    end
  end

  initial begin
    // Start held through reset must not launch; a fresh press must.
    reset = 1'b0; start = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(10);
    start = 1'b0;
    tick();
    press(16'h1234, 16'h0003);
    tick(20);

    // Plain press, then the 0xA5A5 add pattern with lsb forced high in idle.
    press(16'($urandom), 16'($urandom));
    tick(20);
    press(16'h00FF, 16'hA5A5);
    tick(19);
    lsb_force = 1'b1;
    tick(4);
    press(16'h3C3C, 16'h0000);
    tick(22);
    lsb_force = 1'b0;
    tick(2);

    // Start held through done and toggled during iterate.
    op_a = 16'h0101; op_b = 16'h8001; start = 1'b1;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      start = 1'b0; tick();
      start = 1'b1; tick();
    end
    tick(20);
    start = 1'b0;
    tick();
    press(16'h0F0F, 16'h1111);
    tick(20);

    // Reset while iteration == 7, then a full operation.
    press(16'h7777, 16'h5555);
    tick(8);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick(3);
    press(16'h0002, 16'hFFFF);
    tick(20);

    // Back-to-back at the minimum press-to-press period.
    press(16'hFFFF, 16'hFFFF);
    tick(18);
    press(16'h0000, 16'h1234);
    tick(20);

    // Random start activity.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) reset = 1'b0;
      tick();
      reset = 1'b1;
    end
    start = 1'b0;
    tick(22);

    #6;
    checks++;
    if (prod_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending products=%0d cycles=%0d required 0", prod_q.size(), exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
